// File: rtl/beamform_pkg.sv
// Shared definitions for the beamforming delay path: FSM encoding, default width, latencies.
// Latency constants count cycles from the accepting edge to the valid pulse.
// No flow control here; consumers use busy/valid handshakes.
package beamform_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ABS   = 3'd1,
        MUL_X = 3'd2,
        MUL_Z = 3'd3,
        MUL_Y = 3'd4,
        ACC   = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam int BF_W            = 16;
    localparam int BF_SUMSQ_LAT    = 2 * BF_W + 3;
    localparam int BF_SUMSQ_LAT_3D = 3 * BF_W + 3;

endpackage

// File: rtl/usq_serial_mul.sv
// Unsigned serial squarer: presents one shifted partial product of a*a per step, W steps per operand.
// Latency: W step cycles; done pulses with the last partial product, counter then wraps to 0.
// No backpressure: the caller drives step each cycle and consumes pp combinationally.
module usq_serial_mul #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           step,
    input  logic [W-1:0]   a,
    output logic [2*W-1:0] pp,
    output logic           done
);
    localparam int CW = $clog2(W);

    logic [CW-1:0]  cnt;
    logic [2*W-1:0] a_ext;

    assign a_ext = {{W{1'b0}}, a};
    assign done  = step && (cnt == CW'(W - 1));
    assign pp    = a[cnt] ? (a_ext << cnt) : '0;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= done ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dist_sumsq.sv
// Serial sum of squared signed deltas (dx^2+dz^2, plus dy^2 when DIST_SUMSQ_3D_EN is defined).
// Latency: valid at T+2W+3 after the accepting edge (T+3W+3 in 3D); one request in flight.
// Backpressure: start is only accepted while busy==0; requests during busy are dropped.
module dist_sumsq
    import beamform_pkg::*;
#(
    parameter int W = BF_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   dx,
    input  logic [W-1:0]   dz,
`ifdef DIST_SUMSQ_3D_EN
    input  logic [W-1:0]   dy,
`endif
    output logic           busy,
    output logic           valid,
    output logic [2*W-1:0] dout
);
    state_t         state, state_nxt;
    logic [W-1:0]   op_x, op_z, mag_x, mag_z, mul_a;
    logic [2*W-1:0] acc, pp;
    logic           mul_load, mul_step, mul_done;
`ifdef DIST_SUMSQ_3D_EN
    logic [W-1:0]   op_y, mag_y;
`endif

    // Most-negative input maps to 2^(W-1), which still fits the unsigned W-bit magnitude.
    function automatic logic [W-1:0] mag_of(input logic [W-1:0] d);
        return d[W-1] ? (~d + 1'b1) : d;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = ABS;
            ABS:   state_nxt = MUL_X;
            MUL_X: if (mul_done) state_nxt = MUL_Z;
`ifdef DIST_SUMSQ_3D_EN
            MUL_Z: if (mul_done) state_nxt = MUL_Y;
            MUL_Y: if (mul_done) state_nxt = ACC;
`else
            MUL_Z: if (mul_done) state_nxt = ACC;
`endif
            ACC:   state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        valid    = (state == DONE);
        mul_load = (state == ABS);
        mul_step = (state == MUL_X) || (state == MUL_Z) || (state == MUL_Y);
        mul_a    = mag_x;
        if (state == MUL_Z) mul_a = mag_z;
`ifdef DIST_SUMSQ_3D_EN
        if (state == MUL_Y) mul_a = mag_y;
`endif
    end

    usq_serial_mul #(.W(W)) u_mul (
        .clk   (clk),
        .reset (reset),
        .load  (mul_load),
        .step  (mul_step),
        .a     (mul_a),
        .pp    (pp),
        .done  (mul_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            op_x  <= '0;
            op_z  <= '0;
            mag_x <= '0;
            mag_z <= '0;
            acc   <= '0;
            dout  <= '0;
`ifdef DIST_SUMSQ_3D_EN
            op_y  <= '0;
            mag_y <= '0;
`endif
        end else begin
            if (state == IDLE && start) begin
                op_x <= dx;
                op_z <= dz;
`ifdef DIST_SUMSQ_3D_EN
                op_y <= dy;
`endif
            end
            if (state == ABS) begin
                mag_x <= mag_of(op_x);
                mag_z <= mag_of(op_z);
`ifdef DIST_SUMSQ_3D_EN
                mag_y <= mag_of(op_y);
`endif
                acc   <= '0;
            end
            if (mul_step) acc <= acc + pp;
            if (state == ACC) dout <= acc;
        end
    end

endmodule

// File: tb/tb_dist_sumsq.sv
// Bench for dist_sumsq: vector table plus hand sequences, results checked through a latency-tagged queue.
module tb_dist_sumsq;
    import beamform_pkg::*;

    localparam int W = 16;
`ifdef DIST_SUMSQ_3D_EN
    localparam int LAT = BF_SUMSQ_LAT_3D;
`else
    localparam int LAT = BF_SUMSQ_LAT;
`endif

    typedef struct {
        logic [W-1:0]   dx;
        logic [W-1:0]   dz;
        logic [W-1:0]   dy;
        logic [2*W-1:0] exp;
    } vec_t;

    typedef struct {
        logic [2*W-1:0] exp;
        int             t;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   dx = '0;
    logic [W-1:0]   dz = '0;
`ifdef DIST_SUMSQ_3D_EN
    logic [W-1:0]   dy = '0;
`endif
    logic           busy, valid;
    logic [2*W-1:0] dout;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t q[$];
    vec_t vecs[9];

    dist_sumsq #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .dx    (dx),
        .dz    (dz),
`ifdef DIST_SUMSQ_3D_EN
        .dy    (dy),
`endif
        .busy  (busy),
        .valid (valid),
        .dout  (dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every valid must match the oldest expectation at exactly LAT cycles.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_valid: cycle %0d dout=%0h, no result expected", cyc, dout);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (dout !== e.exp || (cyc - e.t) != LAT) begin
                    fails++;
                    $display("FAIL result: dout=%0h after %0d cycles, expected %0h after %0d",
                             dout, cyc - e.t, e.exp, LAT);
                end
            end
        end else if (q.size() > 0 && (cyc - q[0].t) > LAT) begin
            exp_t e;
            e = q.pop_front();
            tests++;
            fails++;
            $display("FAIL missing_valid: no valid %0d cycles after start, expected dout=%0h", LAT, e.exp);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        dx = v.dx;
        dz = v.dz;
`ifdef DIST_SUMSQ_3D_EN
        dy = v.dy;
`endif
    endtask

    task automatic send(input vec_t v, input bit push);
        drive(v);
        start = 1'b1;
        if (push) q.push_back('{exp: v.exp, t: cyc});
        step(1);
        start = 1'b0;
    endtask

    initial begin
        vecs[0] = '{dx: 16'd3,      dz: 16'd4,      dy: 16'd0, exp: 32'd25};
        vecs[1] = '{dx: 16'h8000,   dz: 16'h8000,   dy: 16'd0, exp: 32'h8000_0000};
        vecs[2] = '{dx: 16'd0,      dz: 16'd0,      dy: 16'd0, exp: 32'd0};
        vecs[3] = '{dx: -16'sd7,    dz: 16'd24,     dy: 16'd0, exp: 32'd625};
        vecs[4] = '{dx: 16'd5,      dz: 16'd12,     dy: 16'd0, exp: 32'd169};
        vecs[5] = '{dx: 16'h7FFF,   dz: 16'hFFFF,   dy: 16'd0, exp: 32'd1073676290};
        vecs[6] = '{dx: 16'hFFFF,   dz: 16'hFFFF,   dy: 16'd0, exp: 32'd2};
        vecs[7] = '{dx: 16'd100,    dz: -16'sd100,  dy: 16'd0, exp: 32'd20000};
        vecs[8] = '{dx: 16'h8000,   dz: 16'd0,      dy: 16'd0, exp: 32'h4000_0000};

        step(3);
        reset = 1'b0;
        step(1);
        check("reset_busy",  {63'd0, busy},  64'd0);
        check("reset_valid", {63'd0, valid}, 64'd0);
        check("reset_dout",  {32'd0, dout},  64'd0);

        // Single request: busy stays high through DONE and drops the cycle after.
        send(vecs[0], 1'b1);
        step(LAT - 1);
        check("busy_in_done", {63'd0, busy}, 64'd1);
        step(1);
        check("busy_after_done", {63'd0, busy}, 64'd0);
        check("dout_held", {32'd0, dout}, 64'd25);

        for (int i = 1; i < 9; i++) begin
            send(vecs[i], 1'b1);
            step(LAT);
        end

        // Second start while busy is dropped.
        send('{dx: 16'd1, dz: 16'd1, dy: 16'd0, exp: 32'd2}, 1'b1);
        step(8);
        send('{dx: 16'd100, dz: 16'd100, dy: 16'd0, exp: 32'd0}, 1'b0);
        step(LAT - 9);
        check("drop_idle", {63'd0, busy}, 64'd0);

        // Reset at T+20 aborts the computation.
        send(vecs[4], 1'b0);
        step(19);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("abort_busy",  {63'd0, busy},  64'd0);
        check("abort_valid", {63'd0, valid}, 64'd0);
        check("abort_dout",  {32'd0, dout},  64'd0);
        step(LAT);
        check("abort_quiet_dout", {32'd0, dout}, 64'd0);
        send(vecs[4], 1'b1);
        step(LAT);

        // start held high: one accept every LAT+1 cycles.
        drive(vecs[3]);
        start = 1'b1;
        for (int i = 0; i < 3; i++) q.push_back('{exp: 32'd625, t: cyc + i * (LAT + 1)});
        step(3 * (LAT + 1));
        start = 1'b0;
        step(LAT + 1);

`ifdef DIST_SUMSQ_3D_EN
        send('{dx: 16'd2, dz: 16'd6, dy: 16'd3, exp: 32'd49}, 1'b1);
        step(LAT);
        send('{dx: 16'h8000, dz: 16'h8000, dy: 16'h8000, exp: 32'hC000_0000}, 1'b1);
        step(LAT);
`endif

        step(4);
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
